// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: ctrl codes and a shift-op helper.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHL  = 3'b001;
    localparam logic [2:0] USR_SHR  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROTL = 3'b100;
    localparam logic [2:0] USR_ROTR = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    // True for the ops that move bits and therefore advance the shift counter.
    function automatic logic is_shift(input logic [2:0] ctrl);
        return (ctrl == USR_SHL)  || (ctrl == USR_SHR) ||
               (ctrl == USR_ROTL) || (ctrl == USR_ROTR) ||
               (ctrl == USR_ASR);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Shift counter with wrap at WIDTH shifts and a registered one-cycle frame_done pulse.
module usr_shift_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          frame_done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Count enabled shifts; load/clear restart the frame, the WIDTH-th shift wraps and pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            frame_done <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt        <= '0;
                frame_done <= 1'b1;
            end else begin
                cnt        <= cnt + 1'b1;
                frame_done <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_register_p.sv
// Universal shift register: data register, op mux, serial outputs and the frame counter.
module universal_shift_register_p
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] q_next;
    logic             restart;

    assign restart  = (ctrl == USR_LOAD) || (ctrl == USR_CLR);
    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

    // Next register value for every ctrl code; anything unexpected holds.
    always_comb begin
        q_next = q;
        case (ctrl)
            USR_HOLD: q_next = q;
            USR_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            USR_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            USR_LOAD: q_next = d;
            USR_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROTR: q_next = {q[0], q[WIDTH-1:1]};
            USR_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            USR_CLR:  q_next = '0;
            default:  q_next = q;
        endcase
    end

    // Data register only moves on enabled edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

    usr_shift_counter #(
        .WIDTH(WIDTH),
        .CW   (CW)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .inc       (is_shift(ctrl)),
        .clr       (restart),
        .cnt       (cnt),
        .frame_done(frame_done)
    );

endmodule

// File: tb/tb_universal_shift_register_p.sv
// Scoreboard bench for the universal shift register at WIDTH=8 and WIDTH=16.
module tb_universal_shift_register_p;

    typedef struct {
        logic [63:0] q;
        int          cnt;
        bit          fd;
    } mstate_t;

    typedef struct {
        bit      sel16;
        mstate_t s;
    } sb_entry_t;

    logic        clk;
    logic        reset;

    logic        en8, sl8, sr8;
    logic [2:0]  ctrl8;
    logic [7:0]  d8, q8;
    logic        msb8, lsb8, fd8;
    logic [3:0]  cnt8;

    logic        en16, sl16, sr16;
    logic [2:0]  ctrl16;
    logic [15:0] d16, q16;
    logic        msb16, lsb16, fd16;
    logic [4:0]  cnt16;

    mstate_t     m8, m16;
    sb_entry_t   sbq[$];
    int          errors = 0;
    int          checks = 0;

    universal_shift_register_p #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .ctrl(ctrl8), .d(d8),
        .sin_l(sl8), .sin_r(sr8), .q(q8), .sout_msb(msb8), .sout_lsb(lsb8),
        .cnt(cnt8), .frame_done(fd8)
    );

    universal_shift_register_p #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .en(en16), .ctrl(ctrl16), .d(d16),
        .sin_l(sl16), .sin_r(sr16), .q(q16), .sout_msb(msb16), .sout_lsb(lsb16),
        .cnt(cnt16), .frame_done(fd16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic mstate_t modelNext(input int w, input mstate_t s, input bit e,
                                          input logic [2:0] c, input logic [63:0] dv,
                                          input bit sl, input bit sr);
        mstate_t     n;
        logic [63:0] mask;
        logic [63:0] msb, lsb;
        bit          shift;
        n     = s;
        mask  = (64'd1 << w) - 64'd1;
        msb   = {63'd0, s.q[w-1]};
        lsb   = {63'd0, s.q[0]};
        shift = (c == 3'b001) || (c == 3'b010) || (c == 3'b100) || (c == 3'b101) || (c == 3'b110);
        n.fd  = 1'b0;
        if (e) begin
            case (c)
                3'b001:  n.q = ((s.q << 1) | {63'd0, sr}) & mask;
                3'b010:  n.q = (s.q >> 1) | ({63'd0, sl} << (w - 1));
                3'b011:  n.q = dv & mask;
                3'b100:  n.q = ((s.q << 1) | msb) & mask;
                3'b101:  n.q = (s.q >> 1) | (lsb << (w - 1));
                3'b110:  n.q = (s.q >> 1) | (msb << (w - 1));
                3'b111:  n.q = 64'd0;
                default: n.q = s.q;
            endcase
            if (c == 3'b011 || c == 3'b111) begin
                n.cnt = 0;
            end else if (shift) begin
                if (s.cnt == w - 1) begin
                    n.cnt = 0;
                    n.fd  = 1'b1;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic compareEntry(input sb_entry_t x);
        if (x.sel16) begin
            checkOutput("w16_q",   64'(q16),   x.s.q);
            checkOutput("w16_cnt", 64'(cnt16), 64'(x.s.cnt));
            checkOutput("w16_fd",  64'(fd16),  64'(x.s.fd));
            checkOutput("w16_msb", 64'(msb16), 64'(x.s.q[15]));
            checkOutput("w16_lsb", 64'(lsb16), 64'(x.s.q[0]));
        end else begin
            checkOutput("w8_q",    64'(q8),    x.s.q);
            checkOutput("w8_cnt",  64'(cnt8),  64'(x.s.cnt));
            checkOutput("w8_fd",   64'(fd8),   64'(x.s.fd));
            checkOutput("w8_msb",  64'(msb8),  64'(x.s.q[7]));
            checkOutput("w8_lsb",  64'(lsb8),  64'(x.s.q[0]));
        end
    endtask

    // Drive one cycle on the selected instance (the other idles), push expectations, compare after the edge.
    task automatic applyStimulus(input bit sel16, input bit e, input logic [2:0] c,
                                 input logic [63:0] dv, input bit sl, input bit sr);
        sb_entry_t x;
        en8  = sel16 ? 1'b0 : e;
        en16 = sel16 ? e : 1'b0;
        ctrl8 = c; ctrl16 = c;
        d8 = dv[7:0]; d16 = dv[15:0];
        sl8 = sl; sl16 = sl; sr8 = sr; sr16 = sr;
        m8  = modelNext(8,  m8,  sel16 ? 1'b0 : e, c, dv, sl, sr);
        m16 = modelNext(16, m16, sel16 ? e : 1'b0, c, dv, sl, sr);
        x.sel16 = 1'b0; x.s = m8;  sbq.push_back(x);
        x.sel16 = 1'b1; x.s = m16; sbq.push_back(x);
        @(posedge clk);
        #1;
        while (sbq.size() > 0) compareEntry(sbq.pop_front());
    endtask

    function automatic mstate_t zeroState();
        mstate_t z;
        z.q = 64'd0; z.cnt = 0; z.fd = 1'b0;
        return z;
    endfunction

    initial begin
        logic [7:0]  pat;
        logic [15:0] word;
        pat  = 8'b0100_1101;
        word = 16'hBEEF;
        reset = 1'b0;
        en8 = 0; en16 = 0; ctrl8 = 0; ctrl16 = 0; d8 = 0; d16 = 0;
        sl8 = 0; sl16 = 0; sr8 = 0; sr16 = 0;
        m8 = zeroState(); m16 = zeroState();
        #3;
        checkOutput("rst_q", 64'(q8), 64'd0);
        checkOutput("rst_cnt", 64'(cnt8), 64'd0);
        checkOutput("rst_fd", 64'(fd8), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Case 1: load, rotate left, rotate right
        applyStimulus(0, 1, 3'b011, 64'hA5, 0, 0);
        checkOutput("c1_load", 64'(q8), 64'hA5);
        applyStimulus(0, 1, 3'b100, 64'h0, 0, 0);
        checkOutput("c1_rotl", 64'(q8), 64'h4B);
        checkOutput("c1_msb", 64'(msb8), 64'd0);
        applyStimulus(0, 1, 3'b101, 64'h0, 0, 0);
        checkOutput("c1_rotr", 64'(q8), 64'hA5);

        // Case 2: serial-in on the right shift, pulse after the eighth shift
        applyStimulus(0, 1, 3'b011, 64'h0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'b010, 64'h0, pat[i], 0);
        checkOutput("c2_q", 64'(q8), 64'h4D);
        checkOutput("c2_fd", 64'(fd8), 64'd1);
        applyStimulus(0, 1, 3'b000, 64'h0, 0, 0);
        checkOutput("c2_fd_off", 64'(fd8), 64'd0);

        // Case 3: arithmetic shift then left shift
        applyStimulus(0, 1, 3'b011, 64'h80, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'b110, 64'h0, 0, 0);
        checkOutput("c3_asr", 64'(q8), 64'hF0);
        applyStimulus(0, 1, 3'b001, 64'h0, 0, 1);
        checkOutput("c3_shl", 64'(q8), 64'hE1);
        checkOutput("c3_cnt", 64'(cnt8), 64'd4);

        // Case 4: disabled shifts hold everything, then finish the frame
        applyStimulus(0, 1, 3'b001, 64'h0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 3'b001, 64'h0, 0, 1);
        checkOutput("c4_hold_cnt", 64'(cnt8), 64'd5);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'b001, 64'h0, 0, 1);
        checkOutput("c4_fd", 64'(fd8), 64'd1);
        checkOutput("c4_cnt", 64'(cnt8), 64'd0);

        // Case 5: load on the would-be wrap cycle suppresses the pulse
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 3'b100, 64'h0, 0, 0);
        applyStimulus(0, 1, 3'b011, 64'h3C, 0, 0);
        checkOutput("c5_fd", 64'(fd8), 64'd0);
        checkOutput("c5_q", 64'(q8), 64'h3C);
        applyStimulus(0, 1, 3'b111, 64'h0, 0, 0);
        checkOutput("c5_clr", 64'(q8), 64'd0);

        // Case 6: asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 3'b001, 64'h0, 0, 1);
        checkOutput("c6_pre_cnt", 64'(cnt8), 64'd6);
        en8 = 0; en16 = 0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("c6_async_q", 64'(q8), 64'd0);
        checkOutput("c6_async_cnt", 64'(cnt8), 64'd0);
        m8 = zeroState(); m16 = zeroState();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 3'b001, 64'h0, 0, 1);
        checkOutput("c6_cnt1", 64'(cnt8), 64'd1);

        // Case 6b: sixteen-bit frame shifting 16'hBEEF in LSB first
        applyStimulus(1, 1, 3'b011, 64'h0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 3'b010, 64'h0, word[i], 0);
            if (i < 15) checkOutput("c6_w16_early_fd", 64'(fd16), 64'd0);
        end
        checkOutput("c6_w16_q", 64'(q16), 64'hBEEF);
        checkOutput("c6_w16_fd", 64'(fd16), 64'd1);

        // Random mixed ops on both widths
        for (int i = 0; i < 200; i++) begin
            applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)), {$urandom, $urandom},
                          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_register_p.md
Name: universal_shift_register_p

Overview:
Parametrised next-generation universal shift register. It supports WIDTH-bit hold, logical, rotate and arithmetic shift, parallel load and clear, and has serial inputs and outputs at both ends. A shift counter and a one-cycle frame_done pulse let it act directly as a serial-to-parallel or parallel-to-serial converter for the UART/SPI-style blocks that follow in the class sequence.

Parameters:
WIDTH, 8, register width in bits (legal range 2..64).
CW, $clog2(WIDTH+1), shift-counter width (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserting low clears state immediately).
en  input  1  operation enable; 0 = full hold of all state.
ctrl  input  3  operation select (see Behaviour).
d  input  WIDTH  parallel load data.
sin_l  input  1  serial input entering the MSB on right shift.
sin_r  input  1  serial input entering the LSB on left shift.
q  output  WIDTH  register contents.
sout_msb  output  1  current q[WIDTH-1] (serial out for left shifting).
sout_lsb  output  1  current q[0] (serial out for right shifting).
cnt  output  CW  number of shifts since the last load, clear or wrap.
frame_done  output  1  registered one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Reset (reset==0, async): q=0, cnt=0, frame_done=0. All outputs hold these values until the first rising clk edge after reset goes high.
- Reset asserted mid-frame: the partial count is discarded; the first shift after release gives cnt=1.
- ctrl encoding; takes effect on the edge where en==1:
  - 000 HOLD: no change.
  - 001 SHL: q = {q[W-2:0], sin_r}.
  - 010 SHR: q = {sin_l, q[W-1:1]}.
  - 011 LOAD: q = d.
  - 100 ROTL: q = {q[W-2:0], q[W-1]}.
  - 101 ROTR: q = {q[0], q[W-1:1]}.
  - 110 ASR: q = {q[W-1], q[W-1:1]}.
  - 111 CLEAR: q = 0.
- en==0: q and cnt hold, and frame_done=0 on the next edge, whatever ctrl is.
- Shift ops are 001, 010, 100, 101 and 110. Each enabled shift increments cnt.
- Wrap: if a shift occurs with cnt==WIDTH-1, then on that edge cnt becomes 0 and frame_done becomes 1 for exactly one cycle. cnt never reads WIDTH.
- LOAD and CLEAR set cnt=0 and frame_done=0, overriding any pending wrap.
- HOLD leaves cnt unchanged and sets frame_done=0.
- sout_msb and sout_lsb are combinational from q, so they carry zero added latency.
- Latency: q, cnt and frame_done all reflect an op one clock after the sampling edge.
- Next-state logic is one combinational block with a full case (default = hold), so no latches are inferred.

Decomposition:
- Package usr_pkg holds:
  - localparams for the 3-bit ctrl codes (USR_HOLD, USR_SHL, USR_SHR, USR_LOAD, USR_ROTL, USR_ROTR, USR_ASR, USR_CLR);
  - helper function is_shift(ctrl).
- Sub-module usr_shift_counter (params WIDTH and CW; inputs clk, reset, en, inc, clr; outputs cnt, frame_done) holds the counter, the wrap logic and the pulse register.
- The top level holds the data register, the mux and the serial outputs.

Test Plan:
1. WIDTH=8. Reset low, then high; LOAD d=8'hA5 -> q=8'hA5, cnt=0. Then ROTL x1 -> q=8'h4B, sout_msb=0; ROTR x1 -> q=8'hA5.
2. SHR with sin_l pattern 1,0,1,1,0,0,1,0 over 8 cycles, en=1 -> after 8th edge q=8'h4D, cnt=0, frame_done high for exactly 1 cycle.
3. LOAD 8'h80, then ASR x3 -> q=8'hF0. Then SHL x1 with sin_r=1 -> q=8'hE1, cnt=4.
4. cnt=5; en=0 for 4 cycles with ctrl=SHL -> q and cnt unchanged, frame_done=0. Then en=1 and 3 shifts -> frame_done pulse, cnt=0.
5. 7 shifts, then LOAD on the 8th cycle -> no frame_done, cnt=0, q=d. CLEAR -> q=0.
6. Drop reset asynchronously between clock edges at cnt=6 -> q=0, cnt=0 immediately. After release, 1 shift -> cnt=1. Repeat case 2 with WIDTH=16 (shift 16'hBEEF in) -> pulse after the 16th shift.
